sw_sb_irq_ctrl: RTL and testbench

Switch-bank peripheral controller on the system bus. Synchronizes and debounces 16 slide switches, latches per-bit change flags, and raises a maskable interrupt request toward the core. It runs a request/return handshake with the interrupt logic. Registers are accessed through the standard system-bus slave port (`req_i`, `write_enable_i`, `addr_i`, `write_data_i`, `read_data_o`).

---
 rtl/sw_sb_irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_sw_sb_irq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_sb_irq_ctrl.sv
// Switch-bank controller: synchronizes and debounces 16 switches, latches change flags and
// raises a maskable interrupt with a request/return handshake. Bus-mapped register file.
module sw_sb_irq_ctrl #(
   parameter logic [15:0] DEBOUNCE_RST = 16'd1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   input  logic [15:0] sw_i,
   output logic        interrupt_request_o,
   input  logic        interrupt_return_i
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPend = 2'd1,
      StHold = 2'd2
   } state_e;

   localparam logic [2:0] AddrData   = 3'd0;
   localparam logic [2:0] AddrFlags  = 3'd1;
   localparam logic [2:0] AddrMask   = 3'd2;
   localparam logic [2:0] AddrPeriod = 3'd3;
   localparam logic [2:0] AddrStatus = 3'd4;

   state_e      state_q, state_d;
   logic [15:0] sync1_q, sync_q;
   logic [15:0] deb_q, deb_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] flags_q, flags_d;
   logic [15:0] mask_q, mask_d;
   logic [15:0] period_q, period_d;
   logic [31:0] read_data_q, read_data_d;

   logic        wr_en, rd_en, changed, commit;
   logic [2:0]  sel;
   logic [15:0] n_eff, w1c_bits, set_bits;
   logic        unused_bits;

   assign sel    = addr_i[4:2];
   assign wr_en  = req_i & write_enable_i;
   assign rd_en  = req_i & ~write_enable_i;
   assign unused_bits = ^{addr_i[31:5], addr_i[1:0], write_data_i[31:16]};

   // A change is seen on the edge where the second stage picks up a new value.
   assign changed = (sync1_q != sync_q);
   assign n_eff   = (period_q == 16'd0) ? 16'd1 : period_q;
   assign commit  = !changed && (cnt_q == n_eff - 16'd1) && (sync_q != deb_q);

   assign w1c_bits = (wr_en && sel == AddrFlags) ? write_data_i[15:0] : 16'd0;
   assign set_bits = commit ? (sync_q ^ deb_q) : 16'd0;

   always_comb begin
      cnt_d    = cnt_q;
      deb_d    = deb_q;
      mask_d   = mask_q;
      period_d = period_q;
      if (wr_en && sel == AddrPeriod) begin
         period_d = write_data_i[15:0];
         cnt_d    = 16'd0;
      end else if (changed) begin
         cnt_d = 16'd0;
      end else if (cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (commit) begin
         deb_d = sync_q;
      end
      if (wr_en && sel == AddrMask) begin
         mask_d = write_data_i[15:0];
      end
      // Set after clear so a same-cycle commit wins over the W1C.
      flags_d = (flags_q & ~w1c_bits) | set_bits;
   end

   always_comb begin
      read_data_d = read_data_q;
      if (rd_en) begin
         case (sel)
            AddrData:   read_data_d = {16'd0, deb_q};
            AddrFlags:  read_data_d = {16'd0, flags_q};
            AddrMask:   read_data_d = {16'd0, mask_q};
            AddrPeriod: read_data_d = {16'd0, period_q};
            AddrStatus: read_data_d = {30'd0, state_q};
            default:    read_data_d = 32'd0;
         endcase
      end
   end

   always_comb begin
      state_d             = state_q;
      interrupt_request_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (|(flags_q & mask_q)) begin
               state_d = StPend;
            end
         end
         StPend: begin
            interrupt_request_o = 1'b1;
            if (interrupt_return_i) begin
               state_d = StHold;
            end
         end
         StHold:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         sync1_q     <= 16'd0;
         sync_q      <= 16'd0;
         deb_q       <= 16'd0;
         cnt_q       <= 16'd0;
         flags_q     <= 16'd0;
         mask_q      <= 16'd0;
         period_q    <= DEBOUNCE_RST;
         read_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sw_i;
         sync_q      <= sync1_q;
         deb_q       <= deb_d;
         cnt_q       <= cnt_d;
         flags_q     <= flags_d;
         mask_q      <= mask_d;
         period_q    <= period_d;
         read_data_q <= read_data_d;
      end
   end

   assign read_data_o = read_data_q;

endmodule

// File: tb/tb_sw_sb_irq_ctrl.sv
// Scoreboard bench for sw_sb_irq_ctrl: reads push expected data, a monitor checks the
// registered read data one cycle later; interrupt pin is checked directly.
module tb_sw_sb_irq_ctrl;

   localparam logic [31:0] AData   = 32'h00;
   localparam logic [31:0] AFlags  = 32'h04;
   localparam logic [31:0] AMask   = 32'h08;
   localparam logic [31:0] APeriod = 32'h0C;
   localparam logic [31:0] AStatus = 32'h10;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        write_enable_i = 1'b0;
   logic [31:0] addr_i = 32'd0;
   logic [31:0] write_data_i = 32'd0;
   logic [31:0] read_data_o;
   logic [15:0] sw_i = 16'hFFFF;
   logic        interrupt_request_o;
   logic        interrupt_return_i = 1'b0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } rd_exp_t;

   rd_exp_t q[$];
   int      n_checks = 0;
   int      n_err = 0;
   logic    rd_seen = 1'b0;

   sw_sb_irq_ctrl dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .req_i               (req_i),
      .write_enable_i      (write_enable_i),
      .addr_i              (addr_i),
      .write_data_i        (write_data_i),
      .read_data_o         (read_data_o),
      .sw_i                (sw_i),
      .interrupt_request_o (interrupt_request_o),
      .interrupt_return_i  (interrupt_return_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) rd_seen <= req_i && !write_enable_i;

   // Monitor: read data is valid in the cycle following the read strobe.
   always @(negedge clk_i) begin
      if (rd_seen) begin
         n_checks++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL rd_unexpected: got %h with no expected entry", read_data_o);
         end else begin
            rd_exp_t e;
            e = q.pop_front();
            if (read_data_o !== e.exp) begin
               n_err++;
               $display("FAIL %s: got %h expected %h", e.name, read_data_o, e.exp);
            end
         end
      end
   end

   task automatic chk(input logic act, input logic exp, input string name);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      rd_exp_t e;
      e.exp  = exp;
      e.name = name;
      q.push_back(e);
      req_i = 1'b1;
      write_enable_i = 1'b0;
      addr_i = a;
      idle(1);
      req_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      req_i = 1'b1;
      write_enable_i = 1'b1;
      addr_i = a;
      write_data_i = d;
      idle(1);
      req_i = 1'b0;
      write_enable_i = 1'b0;
   endtask

   task automatic ret_pulse();
      interrupt_return_i = 1'b1;
      idle(1);
      interrupt_return_i = 1'b0;
   endtask

   initial begin
      int k;
      // Reset with switches high
      idle(3);
      chk(interrupt_request_o, 1'b0, "irq_in_reset");
      rst_ni = 1'b1;
      idle(1);
      rd(AData, 32'h0, "rst_data");
      rd(AFlags, 32'h0, "rst_flags");
      rd(AMask, 32'h0, "rst_mask");
      rd(APeriod, 32'd1000, "rst_period");
      rd(AStatus, 32'h0, "rst_status");
      chk(interrupt_request_o, 1'b0, "rst_irq");
      sw_i = 16'h0000;
      wr(APeriod, 32'd4);
      idle(10);
      rd(APeriod, 32'd4, "period_rb");

      // Debounce latency: deb updates on edge 6 after the pin change
      sw_i = 16'h0001;
      idle(5);
      rd(AData, 32'h0, "deb_edge6_pre");
      rd(AData, 32'h1, "deb_edge6_post");
      rd(AFlags, 32'h1, "deb_flags");
      wr(AFlags, 32'h1);
      rd(AFlags, 32'h0, "w1c_clear");

      // Glitch shorter than the period is rejected
      sw_i = 16'h0009;
      idle(2);
      sw_i = 16'h0001;
      idle(12);
      rd(AData, 32'h1, "glitch_data");
      rd(AFlags, 32'h0, "glitch_flags");

      // IRQ handshake on bit 0
      wr(AMask, 32'h1);
      chk(interrupt_request_o, 1'b0, "hs_irq_nomask_flag");
      sw_i = 16'h0000;
      idle(6);
      chk(interrupt_request_o, 1'b0, "hs_irq_at_deb");
      idle(1);
      chk(interrupt_request_o, 1'b1, "hs_irq_rise");
      rd(AFlags, 32'h1, "hs_flags");
      wr(AFlags, 32'h1);
      chk(interrupt_request_o, 1'b1, "hs_irq_held_after_w1c");
      ret_pulse();
      chk(interrupt_request_o, 1'b0, "hs_irq_hold");
      rd(AStatus, 32'h2, "hs_status_hold");
      chk(interrupt_request_o, 1'b0, "hs_irq_idle");
      rd(AStatus, 32'h0, "hs_status_idle");
      chk(interrupt_request_o, 1'b0, "hs_irq_stays_low");

      // Masking and re-entry on bit 4
      wr(AMask, 32'h0);
      sw_i = 16'h0010;
      idle(12);
      chk(interrupt_request_o, 1'b0, "mask_off_irq");
      rd(AFlags, 32'h10, "mask_flags");
      wr(AMask, 32'h10);
      chk(interrupt_request_o, 1'b0, "mask_on_same_edge");
      idle(1);
      chk(interrupt_request_o, 1'b1, "mask_on_irq");
      ret_pulse();
      chk(interrupt_request_o, 1'b0, "reentry_low");
      k = 0;
      while (!interrupt_request_o && k < 3) begin
         idle(1);
         k++;
      end
      chk(interrupt_request_o, 1'b1, "reentry_high");

      // Set/clear collision on bit 2
      wr(AFlags, 32'h10);
      ret_pulse();
      idle(3);
      chk(interrupt_request_o, 1'b0, "coll_irq_idle");
      sw_i = 16'h0014;
      idle(5);
      wr(AFlags, 32'h4);
      rd(AFlags, 32'h4, "coll_set_wins");
      rd(AData, 32'h14, "coll_data");

      // Async reset while pending
      wr(AMask, 32'h4);
      idle(1);
      chk(interrupt_request_o, 1'b1, "arst_irq_pend");
      #2;
      rst_ni = 1'b0;
      #1;
      chk(interrupt_request_o, 1'b0, "arst_irq_drop");
      idle(2);
      rst_ni = 1'b1;
      idle(1);
      rd(AMask, 32'h0, "arst_mask");
      rd(AFlags, 32'h0, "arst_flags");
      rd(AStatus, 32'h0, "arst_status");
      idle(3);

      n_checks++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL rd_drain: got %0d pending reads expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
